// File: rtl/xgmii_tlp_tx_engine_pkg.sv
// Shared constants, state encoding and IPv4 header checksum helper for the
// XGMII TLP transmit engine.
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'h544C5021
`endif

package xgmii_tlp_tx_engine_pkg;

    localparam logic [7:0]  XGMII_IDLE       = 8'h07;
    localparam logic [7:0]  XGMII_START      = 8'hFB;
    localparam logic [7:0]  XGMII_TERM       = 8'hFD;
    localparam logic [63:0] PREAMBLE_WORD    = {8'hD5, {6{8'h55}}, XGMII_START};
    localparam logic [63:0] IDLE_WORD        = {8{XGMII_IDLE}};

    localparam logic [15:0] ETH_TYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
    localparam logic [15:0] UDP_PORT_DEFAULT = 16'd3422;
    localparam logic [31:0] MAGIC_TAG        = `MAGIC_CODE;

    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_FCS  = 3'd3,
        ST_IFG  = 3'd4
    } tx_state_e;

    // Only the addresses and TTL vary; the remaining header words are fixed.
    function automatic logic [15:0] ip_hdr_csum(input logic [31:0] src,
                                                input logic [31:0] dst,
                                                input logic [7:0]  ttl);
        logic [31:0] s;
        s = 32'h4500 + 32'h0032 + 32'h0000 + 32'h4000
          + {16'h0, ttl, IP_PROTO_UDP} + 32'h0000
          + {16'h0, src[31:16]} + {16'h0, src[15:0]}
          + {16'h0, dst[31:16]} + {16'h0, dst[15:0]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

endpackage

// File: rtl/xgmii_tlp_tx_engine_if.sv
// TLP source handshake, addressing inputs and XGMII TX lanes of the engine.
interface xgmii_tlp_tx_engine_if;
    logic         tlp_valid;
    logic         tlp_ready;
    logic [127:0] tlp_data;
    logic [31:0]  if_v4addr;
    logic [47:0]  if_macaddr;
    logic [31:0]  dest_v4addr;
    logic [47:0]  dest_macaddr;
    logic [63:0]  xgmii_txd;
    logic [7:0]   xgmii_txc;

    modport master (
        output tlp_valid, tlp_data, if_v4addr, if_macaddr, dest_v4addr, dest_macaddr,
        input  tlp_ready, xgmii_txd, xgmii_txc
    );

    modport slave (
        input  tlp_valid, tlp_data, if_v4addr, if_macaddr, dest_v4addr, dest_macaddr,
        output tlp_ready, xgmii_txd, xgmii_txc
    );
endinterface

// File: rtl/xgmii_tlp_tx_engine_crc32_d64.sv
// Ethernet CRC-32 (reflected) next-state over one 64-bit word, lane 0 first.
module crc32_d64
    import xgmii_tlp_tx_engine_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    output logic [31:0] crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 64; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end
endmodule

// File: rtl/xgmii_tlp_tx_engine.sv
// Wraps one 128-bit TLP in an Ethernet/IPv4/UDP frame and drives it onto XGMII TX
// with CRC-32 FCS and a programmable inter-frame gap.
module xgmii_tlp_tx_engine
    import xgmii_tlp_tx_engine_pkg::*;
#(
    parameter logic [3:0]  Gap     = 4'h1,
    parameter logic [15:0] UdpPort = UDP_PORT_DEFAULT,
    parameter logic [7:0]  IpTtl   = 8'h40
) (
    input  logic                  xgmii_clk,
    input  logic                  sys_rst,
    xgmii_tlp_tx_engine_if.slave  bus,
    output logic [7:0]            xgmii_txpktcount,
    output logic [7:0]            debug
);
    tx_state_e    state_q, state_d;
    logic [3:0]   wcnt_q, wcnt_d;
    logic [63:0]  txd_q, txd_d;
    logic [7:0]   txc_q, txc_d;
    logic [7:0]   pktcnt_q, pktcnt_d;
    logic         ready_q;
    logic         accept;

    logic [127:0] tlp_q;
    logic [47:0]  smac_q, dmac_q;
    logic [31:0]  sip_q, dip_q;
    logic [15:0]  csum_q;
    logic [15:0]  csum_live;
    logic [31:0]  crc_q, crc_next;
    logic [7:0]   fb [64];

    assign csum_live = ip_hdr_csum(bus.if_v4addr, bus.dest_v4addr, IpTtl);
    assign accept    = bus.tlp_valid && ready_q;

    // txd_q always holds the data word currently on the wire, so the CRC
    // advances over exactly what is transmitted.
    crc32_d64 u_crc (
        .crc_in  (crc_q),
        .data    (txd_q),
        .crc_out (crc_next)
    );

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            fb[i]     = dmac_q[8*(5-i) +: 8];
            fb[6 + i] = smac_q[8*(5-i) +: 8];
        end
        fb[12] = ETH_TYPE_IPV4[15:8];
        fb[13] = ETH_TYPE_IPV4[7:0];
        fb[14] = 8'h45;            fb[15] = 8'h00;
        fb[16] = 8'h00;            fb[17] = 8'h32;
        fb[18] = 8'h00;            fb[19] = 8'h00;
        fb[20] = 8'h40;            fb[21] = 8'h00;
        fb[22] = IpTtl;            fb[23] = IP_PROTO_UDP;
        fb[24] = csum_q[15:8];     fb[25] = csum_q[7:0];
        for (int i = 0; i < 4; i++) begin
            fb[26 + i] = sip_q[8*(3-i) +: 8];
            fb[30 + i] = dip_q[8*(3-i) +: 8];
            fb[42 + i] = MAGIC_TAG[8*(3-i) +: 8];
        end
        fb[34] = UdpPort[15:8];    fb[35] = UdpPort[7:0];
        fb[36] = UdpPort[15:8];    fb[37] = UdpPort[7:0];
        fb[38] = 8'h00;            fb[39] = 8'h1E;
        fb[40] = 8'h00;            fb[41] = 8'h00;
        fb[46] = 8'h00;            fb[47] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            fb[48 + i] = tlp_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pktcnt_d = pktcnt_q;
        txd_d    = IDLE_WORD;
        txc_d    = 8'hFF;

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_PRE;
            ST_PRE: begin
                state_d = ST_DATA;
                wcnt_d  = 4'd0;
            end
            ST_DATA: begin
                if (wcnt_q == 4'd7) begin
                    state_d  = ST_FCS;
                    pktcnt_d = pktcnt_q + 8'd1;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            ST_FCS: begin
                state_d = ST_IFG;
                wcnt_d  = 4'd0;
            end
            ST_IFG: begin
                if (wcnt_q == Gap) state_d = ST_IDLE;
                else               wcnt_d  = wcnt_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Output word is chosen from the state being entered, so every lane is registered.
        case (state_d)
            ST_PRE: begin
                txd_d = PREAMBLE_WORD;
                txc_d = 8'h01;
            end
            ST_DATA: begin
                for (int l = 0; l < 8; l++) begin
                    txd_d[8*l +: 8] = fb[{wcnt_d[2:0], 3'(l)}];
                end
                txc_d = 8'h00;
            end
            ST_FCS: begin
                txd_d = {XGMII_IDLE, XGMII_IDLE, XGMII_IDLE, XGMII_TERM, ~crc_next};
                txc_d = 8'hF0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            txd_q    <= IDLE_WORD;
            txc_q    <= 8'hFF;
            pktcnt_q <= 8'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            txd_q    <= txd_d;
            txc_q    <= txc_d;
            pktcnt_q <= pktcnt_d;
            ready_q  <= (state_d == ST_IDLE);
        end
    end

    always_ff @(posedge xgmii_clk) begin
        crc_q <= (state_q == ST_DATA) ? crc_next : CRC_INIT;
        if (accept) begin
            tlp_q  <= bus.tlp_data;
            smac_q <= bus.if_macaddr;
            dmac_q <= bus.dest_macaddr;
            sip_q  <= bus.if_v4addr;
            dip_q  <= bus.dest_v4addr;
            csum_q <= csum_live;
        end
    end

    assign bus.tlp_ready    = ready_q;
    assign bus.xgmii_txd    = txd_q;
    assign bus.xgmii_txc    = txc_q;
    assign xgmii_txpktcount = pktcnt_q;
    assign debug            = {state_q, 1'b0, wcnt_q};
endmodule

// File: tb/tb_xgmii_tlp_tx_engine.sv
// Scoreboard bench for xgmii_tlp_tx_engine: a byte-level frame model queues the
// expected XGMII words at every accepted TLP; a monitor pops and compares each cycle.
module tb_xgmii_tlp_tx_engine;
    localparam logic [3:0]  GAP      = 4'h1;
    localparam logic [15:0] UDP_PORT = 16'd3422;
    localparam logic [7:0]  TTL      = 8'h40;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        bit          fcs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pktcount;
    logic [7:0] debug;

    xgmii_tlp_tx_engine_if tif ();

    xgmii_tlp_tx_engine #(.Gap(GAP), .UdpPort(UDP_PORT), .IpTtl(TTL)) dut (
        .xgmii_clk        (clk),
        .sys_rst          (rst),
        .bus              (tif),
        .xgmii_txpktcount (pktcount),
        .debug            (debug)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // Reference frame built byte by byte from the field layout.
    task automatic push_frame(input logic [127:0] tlp, input logic [47:0] smac,
                              input logic [47:0] dmac, input logic [31:0] sip,
                              input logic [31:0] dip);
        logic [7:0]  b[$];
        logic [31:0] sum;
        logic [15:0] ck;
        logic [31:0] crc;
        logic [31:0] magic;
        exp_t        e;
        magic = xgmii_tlp_tx_engine_pkg::MAGIC_TAG;
        for (int i = 5; i >= 0; i--) b.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(smac[8*i +: 8]);
        b.push_back(8'h08); b.push_back(8'h00);
        b.push_back(8'h45); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h32);
        b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
        b.push_back(TTL);   b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(dip[8*i +: 8]);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {16'h0, b[i], b[i+1]};
        sum = (sum & 32'hFFFF) + (sum >> 16);
        sum = (sum & 32'hFFFF) + (sum >> 16);
        ck = ~sum[15:0];
        b[24] = ck[15:8];
        b[25] = ck[7:0];
        for (int k = 0; k < 2; k++) begin
            b.push_back(UDP_PORT[15:8]); b.push_back(UDP_PORT[7:0]);
        end
        b.push_back(8'h00); b.push_back(8'h1E); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(magic[8*i +: 8]);
        b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 0; i < 16; i++) b.push_back(tlp[8*i +: 8]);

        crc = 32'hFFFFFFFF;
        foreach (b[i]) begin
            crc ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end

        e.d = 64'hD5555555555555FB; e.c = 8'h01; e.fcs = 1'b0;
        exp_q.push_back(e);
        for (int w = 0; w < 8; w++) begin
            for (int l = 0; l < 8; l++) e.d[8*l +: 8] = b[8*w + l];
            e.c = 8'h00;
            exp_q.push_back(e);
        end
        e.d = {8'h07, 8'h07, 8'h07, 8'hFD, ~crc}; e.c = 8'hF0; e.fcs = 1'b1;
        exp_q.push_back(e);
        for (int g = 0; g <= int'(GAP); g++) begin
            e.d = 64'h0707070707070707; e.c = 8'hFF; e.fcs = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard feeder: observes the handshake at each edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (tif.tlp_valid && tif.tlp_ready) begin
            push_frame(tif.tlp_data, tif.if_macaddr, tif.dest_macaddr, tif.if_v4addr, tif.dest_v4addr);
        end
    end

    // Monitor: compares the registered outputs just after every edge.
    logic [7:0] exp_cnt = 8'd0;
    always @(posedge clk) begin
        logic  r;
        exp_t  e;
        logic  exp_rdy;
        r = rst;
        #1;
        if (r) begin
            e.d = 64'h0707070707070707; e.c = 8'hFF; e.fcs = 1'b0;
            exp_rdy = 1'b0;
            exp_cnt = 8'd0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_rdy = 1'b0;
            if (e.fcs) exp_cnt = exp_cnt + 8'd1;
        end else begin
            e.d = 64'h0707070707070707; e.c = 8'hFF; e.fcs = 1'b0;
            exp_rdy = 1'b1;
        end
        check("txd", tif.xgmii_txd, e.d);
        check("txc", {56'h0, tif.xgmii_txc}, {56'h0, e.c});
        check("tlp_ready", {63'h0, tif.tlp_ready}, {63'h0, exp_rdy});
        check("pktcount", {56'h0, pktcount}, {56'h0, exp_cnt});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_fields();
        tif.tlp_data     = {$urandom, $urandom, $urandom, $urandom};
        tif.if_macaddr   = {$urandom, $urandom};
        tif.dest_macaddr = {$urandom, $urandom};
        tif.if_v4addr    = $urandom;
        tif.dest_v4addr  = $urandom;
    endtask

    task automatic send_one(input bit scramble);
        bit ok;
        ok = 1'b0;
        tif.tlp_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tif.tlp_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
            if (scramble) rand_fields();
        end
        tif.tlp_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance want acceptance within 200 cycles");
        end
    endtask

    initial begin
        int acc;
        tif.tlp_valid    = 1'b0;
        tif.tlp_data     = '0;
        tif.if_macaddr   = '0;
        tif.dest_macaddr = '0;
        tif.if_v4addr    = '0;
        tif.dest_v4addr  = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (8) tick();

        // Directed frame
        tif.if_macaddr   = 48'h001122334455;
        tif.dest_macaddr = 48'h66778899AABB;
        tif.if_v4addr    = 32'h0A000001;
        tif.dest_v4addr  = 32'h0A000002;
        tif.tlp_data     = 128'h0123456789abcdef_fedcba9876543210;
        send_one(1'b0);
        repeat (20) tick();

        // Three TLPs with valid held high
        acc = 0;
        tif.tlp_valid = 1'b1;
        for (int i = 0; i < 200 && acc < 3; i++) begin
            if (tif.tlp_ready) acc++;
            tick();
            tif.tlp_data = {$urandom, $urandom, $urandom, $urandom};
        end
        tif.tlp_valid = 1'b0;
        n_vec++;
        if (acc != 3) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d accepts want 3", acc);
        end
        repeat (20) tick();

        // Address change while a frame is in flight
        send_one(1'b0);
        repeat (4) tick();
        tif.dest_v4addr  = 32'hC0A80117;
        tif.dest_macaddr = 48'hDEADBEEF0001;
        repeat (12) tick();
        send_one(1'b0);
        repeat (20) tick();

        // Reset in the middle of a frame
        send_one(1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rand_fields();
        send_one(1'b0);
        repeat (20) tick();

        // Long random run, enough frames to wrap the packet counter
        for (int f = 0; f < 260; f++) begin
            rand_fields();
            repeat ($urandom_range(0, 3)) tick();
            send_one(1'b1);
        end
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got no completion want completion before %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
